// File: rtl/mem_io_arbiter_if.sv
// Requester, data-memory and IO signal bundle around mem_io_arbiter.
// slave = arbiter side, master = requesters plus memory/IO peripherals.
interface mem_io_arbiter_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              a_req,   b_req;
    logic              a_we,    b_we;
    logic [31:0]       a_addr,  b_addr;
    logic [31:0]       a_wdata, b_wdata;
    logic [31:0]       a_rdata, b_rdata;
    logic              a_ack,   b_ack;
    logic              a_err,   b_err;
    logic              m_en,    m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;
    logic              io_en,   io_we;
    logic [9:0]        io_addr;
    logic [31:0]       io_wdata;
    logic [15:0]       io_rdata;
    logic              led_cs,  sw_cs;

    modport slave (
        input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
        input  m_rdata, io_rdata,
        output a_rdata, b_rdata, a_ack, b_ack, a_err, b_err,
        output m_en, m_we, m_addr, m_wdata,
        output io_en, io_we, io_addr, io_wdata, led_cs, sw_cs
    );

    modport master (
        output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata,
        output m_rdata, io_rdata,
        input  a_rdata, b_rdata, a_ack, b_ack, a_err, b_err,
        input  m_en, m_we, m_addr, m_wdata,
        input  io_en, io_we, io_addr, io_wdata, led_cs, sw_cs
    );
endinterface

// File: rtl/mem_io_arbiter.sv
// Round-robin arbiter sharing the data-memory / IO path between the CPU (A)
// and the loader/debug master (B); each grant is decoded into MEM, IO or error.
module mem_io_arbiter #(
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned MEM_BYTES = 65536,
    parameter int unsigned ADDR_W    = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_io_arbiter_if.slave bus,
    output logic            busy
);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {R_MEM, R_IO, R_ERR} region_t;

    state_t            state_q,  state_d;
    region_t           region_q, region_d;
    logic              last_b_q, last_b_d;
    logic              gnt_b_q,  gnt_b_d;
    logic              we_q,     we_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    logic              sel_b, sel_we;
    logic [31:0]       sel_addr, sel_wdata;
    logic              cap;
    logic [31:0]       cap_data;
    logic              busy_d;

    logic [31:0]       a_rdata_d, b_rdata_d;
    logic              a_ack_d, b_ack_d, a_err_d, b_err_d;
    logic              m_en_d, m_we_d, io_en_d, io_we_d, led_cs_d, sw_cs_d;
    logic [ADDR_W-1:0] m_addr_d;
    logic [9:0]        io_addr_d;
    logic [31:0]       m_wdata_d, io_wdata_d;

    // IO window takes precedence over the memory range
    function automatic region_t decode(input logic [31:0] addr);
        if (addr[31:10] == 22'h3FFFFF) return R_IO;
        if (addr < 32'(MEM_BYTES))     return R_MEM;
        return R_ERR;
    endfunction

    // B wins only when alone or when A was the last port served
    assign sel_b     = bus.b_req && (!bus.a_req || !last_b_q);
    assign sel_we    = sel_b ? bus.b_we    : bus.a_we;
    assign sel_addr  = sel_b ? bus.b_addr  : bus.a_addr;
    assign sel_wdata = sel_b ? bus.b_wdata : bus.a_wdata;

    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        last_b_d   = last_b_q;
        gnt_b_d    = gnt_b_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        cap        = 1'b0;
        cap_data   = '0;
        a_rdata_d  = bus.a_rdata;
        b_rdata_d  = bus.b_rdata;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_err_d    = 1'b0;
        b_err_d    = 1'b0;
        m_en_d     = 1'b0;
        m_we_d     = 1'b0;
        m_addr_d   = '0;
        m_wdata_d  = '0;
        io_en_d    = 1'b0;
        io_we_d    = 1'b0;
        io_addr_d  = '0;
        io_wdata_d = '0;
        led_cs_d   = 1'b0;
        sw_cs_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    state_d  = S_ACCESS;
                    region_d = decode(sel_addr);
                    last_b_d = sel_b;
                    gnt_b_d  = sel_b;
                    we_d     = sel_we;
                    // downstream strobes are registered so they appear exactly in ACCESS
                    case (region_d)
                        R_MEM: begin
                            m_en_d    = 1'b1;
                            m_we_d    = sel_we;
                            m_addr_d  = sel_addr[ADDR_W+1:2];
                            m_wdata_d = sel_we ? sel_wdata : 32'd0;
                        end
                        R_IO: begin
                            io_en_d    = 1'b1;
                            io_we_d    = sel_we;
                            io_addr_d  = sel_addr[9:0];
                            io_wdata_d = sel_we ? sel_wdata : 32'd0;
                            led_cs_d   = sel_we;
                            sw_cs_d    = !sel_we;
                        end
                        default: ;
                    endcase
                end
            end
            S_ACCESS: begin
                case (region_q)
                    R_MEM: begin
                        cnt_d   = CNT_W'(MEM_LAT - 1);
                        state_d = S_WAIT;
                    end
                    R_IO: begin
                        cap      = !we_q;
                        cap_data = {{16{bus.io_rdata[15]}}, bus.io_rdata};
                        state_d  = S_DONE;
                    end
                    default: begin
                        cap     = !we_q;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    cap      = !we_q;
                    cap_data = bus.m_rdata;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_DONE) begin
            a_ack_d = !gnt_b_q;
            b_ack_d = gnt_b_q;
            a_err_d = !gnt_b_q && (region_q == R_ERR);
            b_err_d = gnt_b_q && (region_q == R_ERR);
        end
        if (cap) begin
            if (gnt_b_q) b_rdata_d = cap_data;
            else         a_rdata_d = cap_data;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            region_q     <= R_MEM;
            last_b_q     <= 1'b1;
            gnt_b_q      <= 1'b0;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            bus.a_rdata  <= '0;
            bus.b_rdata  <= '0;
            bus.a_ack    <= 1'b0;
            bus.b_ack    <= 1'b0;
            bus.a_err    <= 1'b0;
            bus.b_err    <= 1'b0;
            bus.m_en     <= 1'b0;
            bus.m_we     <= 1'b0;
            bus.m_addr   <= '0;
            bus.m_wdata  <= '0;
            bus.io_en    <= 1'b0;
            bus.io_we    <= 1'b0;
            bus.io_addr  <= '0;
            bus.io_wdata <= '0;
            bus.led_cs   <= 1'b0;
            bus.sw_cs    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            region_q     <= region_d;
            last_b_q     <= last_b_d;
            gnt_b_q      <= gnt_b_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            bus.a_rdata  <= a_rdata_d;
            bus.b_rdata  <= b_rdata_d;
            bus.a_ack    <= a_ack_d;
            bus.b_ack    <= b_ack_d;
            bus.a_err    <= a_err_d;
            bus.b_err    <= b_err_d;
            bus.m_en     <= m_en_d;
            bus.m_we     <= m_we_d;
            bus.m_addr   <= m_addr_d;
            bus.m_wdata  <= m_wdata_d;
            bus.io_en    <= io_en_d;
            bus.io_we    <= io_we_d;
            bus.io_addr  <= io_addr_d;
            bus.io_wdata <= io_wdata_d;
            bus.led_cs   <= led_cs_d;
            bus.sw_cs    <= sw_cs_d;
            busy         <= busy_d;
        end
    end
endmodule

// File: tb/tb_mem_io_arbiter.sv
// Randomized scoreboard bench for mem_io_arbiter (MEM_LAT=1) plus a directed
// MEM_LAT=3 instance for long latency, mid-access reset and post-reset tie.
module tb_mem_io_arbiter;
    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned MEM_BYTES = 65536;
    localparam int unsigned WORDS     = MEM_BYTES / 4;
    localparam int unsigned DN_W      = 94;
    localparam int          LAT       = 1;

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
    typedef struct { int cyc; bit port_b; logic [31:0] rdata; bit err; } ack_exp_t;
    typedef struct { int cyc; logic [DN_W-1:0] dn; } acc_exp_t;

    logic clk = 1'b0;
    logic rst_n, rst3_n;
    logic busy, busy3;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_io_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
    mem_io_arbiter_if #(.ADDR_W(ADDR_W)) bus3 ();

    mem_io_arbiter #(.MEM_LAT(1), .MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));
    mem_io_arbiter #(.MEM_LAT(3), .MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .bus(bus3), .busy(busy3));

    // Environment: BRAM with one-cycle read latency, IO peripheral readback from a per-round salt
    logic [31:0] bram    [WORDS];
    logic [31:0] ref_mem [WORDS];
    logic [15:0] io_salt;
    assign bus.io_rdata  = io_salt ^ {6'd0, bus.io_addr};
    assign bus3.io_rdata = 16'h0000;
    assign bus3.m_rdata  = {16'hC0DE, 16'(cyc)};
    always @(posedge clk) begin
        if (bus.m_en && bus.m_we) bram[bus.m_addr] <= bus.m_wdata;
        bus.m_rdata <= (bus.m_en && !bus.m_we) ? bram[bus.m_addr] : $urandom;
    end

    bit          model_last_b = 1'b1;
    logic [31:0] exp_rd_a = '0;
    logic [31:0] exp_rd_b = '0;
    ack_exp_t    ackq[$];
    acc_exp_t    accq[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // 0 = MEM, 1 = IO, 2 = decode error
    function automatic int region_of(input logic [31:0] a);
        if (a >= 32'hFFFF_FC00) return 1;
        if (a < MEM_BYTES)      return 0;
        return 2;
    endfunction

    // Reference: serve one transaction granted in IDLE cycle g, queue expectations, return ack cycle
    function automatic int serve(input bit pb, input txn_t t, input int g);
        int          r    = region_of(t.addr);
        int          done = g + ((r == 0) ? 2 + LAT : 2);
        logic [31:0] rd   = pb ? exp_rd_b : exp_rd_a;
        logic [13:0] w    = t.addr[15:2];
        logic [15:0] s    = io_salt ^ {6'd0, t.addr[9:0]};
        ack_exp_t    e;
        acc_exp_t    x;
        x.cyc = g + 1;
        x.dn  = '0;
        if (r == 0) begin
            x.dn = {1'b1, t.we, w, t.we ? t.wdata : 32'd0, 2'b00, 10'd0, 32'd0, 2'b00};
            if (t.we) ref_mem[w] = t.wdata;
            else      rd = ref_mem[w];
        end else if (r == 1) begin
            x.dn = {2'b00, 14'd0, 32'd0, 1'b1, t.we, t.addr[9:0], t.we ? t.wdata : 32'd0, t.we, !t.we};
            if (!t.we) rd = {{16{s[15]}}, s};
        end else if (!t.we) begin
            rd = '0;
        end
        if (r != 2) accq.push_back(x);
        if (pb) exp_rd_b = rd;
        else    exp_rd_a = rd;
        e.cyc = done; e.port_b = pb; e.rdata = rd; e.err = (r == 2);
        ackq.push_back(e);
        return done;
    endfunction

    function automatic txn_t rand_txn();
        txn_t        t;
        int          k  = int'($urandom_range(0, 9));
        logic [31:0] lo = 32'($urandom_range(0, 3));
        t.we    = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        if (k < 5)       t.addr = (32'($urandom_range(0, 31)) << 2) | lo;
        else if (k == 5) t.addr = 32'h0000_FFFC | lo;
        else if (k < 8)  t.addr = 32'hFFFF_FC00 | 32'($urandom_range(0, 1023));
        else if (k == 8) t.addr = 32'h0001_0000 | lo;
        else             t.addr = $urandom_range(32'hFFFF_FBFF, 32'h0001_0000);
        return t;
    endfunction

    // Raise requests in an IDLE cycle, predict the service order, drop each req after its ack
    task automatic run_round(input bit use_a, input bit use_b, input txn_t ta, input txn_t tb);
        int c, ack1;
        bit pa = use_a;
        bit pb = use_b;
        @(negedge clk);
        c = cyc;
        if (use_a && use_b) begin
            if (model_last_b) begin
                ack1 = serve(1'b0, ta, c);
                void'(serve(1'b1, tb, ack1 + 1));
                model_last_b = 1'b1;
            end else begin
                ack1 = serve(1'b1, tb, c);
                void'(serve(1'b0, ta, ack1 + 1));
                model_last_b = 1'b0;
            end
        end else if (use_a) begin
            void'(serve(1'b0, ta, c));
            model_last_b = 1'b0;
        end else begin
            void'(serve(1'b1, tb, c));
            model_last_b = 1'b1;
        end
        bus.a_req = use_a; bus.a_we = ta.we; bus.a_addr = ta.addr; bus.a_wdata = ta.wdata;
        bus.b_req = use_b; bus.b_we = tb.we; bus.b_addr = tb.addr; bus.b_wdata = tb.wdata;
        for (int k = 0; k < 40 && (pa || pb); k++) begin
            @(negedge clk);
            if (bus.a_ack) begin bus.a_req = 1'b0; pa = 1'b0; end
            if (bus.b_ack) begin bus.b_req = 1'b0; pb = 1'b0; end
        end
        if (pa || pb) begin
            chk("round_timeout", 128'({pa, pb}), 128'(0));
            bus.a_req = 1'b0;
            bus.b_req = 1'b0;
        end
    endtask

    // Monitor: compare every downstream access and every ack against the queued expectations
    initial begin : monitor
        ack_exp_t        e;
        acc_exp_t        x;
        logic [DN_W-1:0] dn;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                dn = {bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata, bus.io_en, bus.io_we,
                      bus.io_addr, bus.io_wdata, bus.led_cs, bus.sw_cs};
                if (dn != '0) begin
                    if (accq.size() == 0) chk("access_unexpected", 128'(dn), 128'(0));
                    else begin
                        x = accq.pop_front();
                        chk("access_cycle",  128'(cyc), 128'(x.cyc));
                        chk("access_fields", 128'(dn),  128'(x.dn));
                    end
                end
                if (bus.a_ack || bus.b_ack) begin
                    if (ackq.size() == 0) chk("ack_unexpected", 128'({bus.a_ack, bus.b_ack}), 128'(0));
                    else begin
                        e = ackq.pop_front();
                        chk("ack_cycle", 128'(cyc), 128'(e.cyc));
                        chk("ack_port", 128'({bus.a_ack, bus.b_ack}), 128'(e.port_b ? 2'b01 : 2'b10));
                        chk("ack_err", 128'({bus.a_err, bus.b_err}),
                            128'(e.err ? (e.port_b ? 2'b01 : 2'b10) : 2'b00));
                        chk("ack_rdata", 128'(e.port_b ? bus.b_rdata : bus.a_rdata), 128'(e.rdata));
                        chk("ack_busy", 128'(busy), 128'(1));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int   c, kind, acks3, ta3, tb3;
        txn_t z;
        z = '0;
        rst_n = 1'b0; rst3_n = 1'b0; io_salt = '0;
        bus.a_req = 0; bus.b_req = 0; bus.a_we = 0; bus.b_we = 0;
        bus.a_addr = '0; bus.b_addr = '0; bus.a_wdata = '0; bus.b_wdata = '0;
        bus3.a_req = 0; bus3.b_req = 0; bus3.a_we = 0; bus3.b_we = 0;
        bus3.a_addr = '0; bus3.b_addr = '0; bus3.a_wdata = '0; bus3.b_wdata = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            bram[i]    = 32'(i) * 32'h9E37_79B1;
            ref_mem[i] = 32'(i) * 32'h9E37_79B1;
        end
        bram[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 128'(|{bus.a_rdata, bus.b_rdata, bus.a_ack, bus.b_ack, bus.a_err, bus.b_err,
            bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata, bus.io_en, bus.io_we, bus.io_addr,
            bus.io_wdata, bus.led_cs, bus.sw_cs}), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        rst_n = 1'b1; rst3_n = 1'b1;

        // Directed: tie after reset, IO read/write, decode error
        run_round(1'b1, 1'b1, '{1'b0, 32'h0000_0010, 32'h0}, '{1'b0, 32'h0000_0014, 32'h0});
        io_salt = 16'h8061;
        run_round(1'b0, 1'b1, z, '{1'b0, 32'hFFFF_FC60, 32'h0});
        run_round(1'b1, 1'b0, '{1'b1, 32'hFFFF_FC62, 32'h5}, z);
        run_round(1'b1, 1'b0, '{1'b0, 32'h0001_0000, 32'h0}, z);
        repeat (4) run_round(1'b1, 1'b1, rand_txn(), rand_txn());

        for (int r = 0; r < 80; r++) begin
            io_salt = 16'($urandom);
            kind    = int'($urandom_range(0, 2));
            run_round(kind != 1, kind != 0, rand_txn(), rand_txn());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // MEM_LAT=3: strobe only in ACCESS, ack four cycles later
        @(negedge clk);
        c = cyc; bus3.a_req = 1'b1; bus3.a_addr = 32'h20;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("lat3_en_ack", 128'({bus3.m_en, bus3.a_ack}),
                128'(k == 1 ? 2'b10 : (k == 5 ? 2'b01 : 2'b00)));
            if (k == 1) chk("lat3_addr", 128'(bus3.m_addr), 128'(8));
        end
        chk("lat3_rdata", 128'(bus3.a_rdata), 128'({16'hC0DE, 16'(c + 4)}));
        bus3.a_req = 1'b0;

        // Reset in the middle of an access: everything clears, nothing completes
        @(negedge clk);
        bus3.a_req = 1'b1; bus3.a_addr = 32'h24;
        repeat (3) @(negedge clk);
        rst3_n = 1'b0;
        #1;
        chk("rst_mid_zero", 128'(|{bus3.a_rdata, bus3.b_rdata, bus3.a_ack, bus3.b_ack, bus3.a_err,
            bus3.b_err, bus3.m_en, bus3.m_we, bus3.m_addr, bus3.m_wdata, bus3.io_en, bus3.io_we,
            bus3.io_addr, bus3.io_wdata, bus3.led_cs, bus3.sw_cs, busy3}), 128'(0));
        bus3.a_req = 1'b0;
        acks3 = 0;
        repeat (3) begin
            @(negedge clk);
            acks3 += int'(bus3.a_ack) + int'(bus3.b_ack);
        end
        rst3_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            acks3 += int'(bus3.a_ack) + int'(bus3.b_ack);
        end
        chk("rst_no_ack", 128'(acks3), 128'(0));

        // After reset A wins the tie; B follows one cycle after A's ack
        c = cyc; bus3.a_req = 1'b1; bus3.a_addr = 32'h28; bus3.b_req = 1'b1; bus3.b_addr = 32'h2C;
        ta3 = -1; tb3 = -1;
        for (int k = 0; k < 20 && tb3 < 0; k++) begin
            @(negedge clk);
            if (bus3.a_ack) begin
                ta3 = cyc; bus3.a_req = 1'b0;
                chk("tie3_a_rdata", 128'(bus3.a_rdata), 128'({16'hC0DE, 16'(c + 4)}));
            end
            if (bus3.b_ack) begin
                tb3 = cyc; bus3.b_req = 1'b0;
                chk("tie3_b_rdata", 128'(bus3.b_rdata), 128'({16'hC0DE, 16'(c + 10)}));
            end
        end
        chk("tie3_a_ack_cycle", 128'(ta3), 128'(c + 5));
        chk("tie3_b_ack_cycle", 128'(tb3), 128'(c + 11));

        repeat (3) @(negedge clk);
        chk("ackq_drained", 128'(ackq.size()), 128'(0));
        chk("accq_drained", 128'(accq.size()), 128'(0));
        chk("busy_idle", 128'({busy, busy3}), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
